dbus_access_ctrl: RTL and testbench

//  Data-bus request controller between the memory-stage register and the data bus. Takes the

---
 rtl/dbus_access_ctrl.sv | 138 +++++++++++++
 tb/tb_dbus_access_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_access_ctrl.sv
// Data-bus request controller: issues one aligned load/store per memory-stage request over a
// valid/addr_ok/data_ok handshake, stalling the pipeline until the access completes.
module dbus_access_ctrl #(
    parameter bit BYPASS_RESP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_accept,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        addr_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, data_q, rdata_q;
    logic [1:0]  size_q;
    logic [3:0]  strobe_q;

    logic        misaligned;
    logic        issue;
    logic        complete;
    logic [3:0]  strobe_new;
    logic [31:0] data_new;
    logic [31:0] shifted;
    state_t      finish_state;

    // size 3 is decoded as a word everywhere, so req_size[1] means "word"
    always_comb begin
        misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        strobe_new = 4'b0000;
        data_new   = req_wdata;
        if (req_size[1]) begin
            strobe_new = 4'b1111;
        end else if (req_size[0]) begin
            strobe_new = 4'b0011 << req_addr[1:0];
            data_new   = {2{req_wdata[15:0]}};
        end else begin
            strobe_new = 4'b0001 << req_addr[1:0];
            data_new   = {4{req_wdata[7:0]}};
        end
        if (!req_write) begin
            strobe_new = 4'b0000;
        end
    end

    assign issue    = (state_q == IDLE) && req_valid && !misaligned;
    assign complete = ((state_q == ADDR) && dresp_addr_ok && dresp_data_ok) ||
                      ((state_q == DATA) && dresp_data_ok);
    assign shifted  = dresp_data >> {addr_q[1:0], 3'b000};

    // A bypassed completion can hand the result over in the same cycle it arrives
    assign finish_state = (BYPASS_RESP && req_accept) ? IDLE : DONE;

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        addr_err = 1'b0;
        rdata    = rdata_q;
        unique case (state_q)
            IDLE: begin
                addr_err = req_valid && misaligned;
                stall    = issue;
                if (issue) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                stall = 1'b1;
                if (dresp_addr_ok) begin
                    state_d = dresp_data_ok ? finish_state : DATA;
                end
            end
            DATA: begin
                stall = 1'b1;
                if (dresp_data_ok) begin
                    state_d = finish_state;
                end
            end
            DONE: begin
                if (req_accept) begin
                    state_d = IDLE;
                end
            end
        endcase
        if (complete && BYPASS_RESP) begin
            stall = 1'b0;
            rdata = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            size_q   <= 2'd0;
            strobe_q <= 4'd0;
            rdata_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                addr_q   <= req_addr;
                data_q   <= data_new;
                size_q   <= req_size;
                strobe_q <= strobe_new;
            end
            if (complete) begin
                rdata_q <= shifted;
            end
        end
    end

    assign dreq_valid  = (state_q == ADDR);
    assign dreq_addr   = addr_q;
    assign dreq_size   = size_q;
    assign dreq_strobe = strobe_q;
    assign dreq_data   = data_q;

endmodule

// File: tb/tb_dbus_access_ctrl.sv
// Bench for dbus_access_ctrl: acts as memory stage and data bus, checks against a transaction-level model.
module tb_dbus_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_accept;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;

    logic        v1, v0, st1, st0, ae1, ae0;
    logic [31:0] a1, a0, d1, d0, r1, r0;
    logic [1:0]  s1, s0;
    logic [3:0]  b1, b0;

    logic        sel;
    logic        o_valid, o_stall, o_err;
    logic [31:0] o_addr, o_data, o_rdata;
    logic [1:0]  o_size;
    logic [3:0]  o_strobe;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbus_access_ctrl #(.BYPASS_RESP(1'b1)) u_byp (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_accept(req_accept),
        .dreq_valid(v1), .dreq_addr(a1), .dreq_size(s1), .dreq_strobe(b1), .dreq_data(d1),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .rdata(r1), .stall(st1), .addr_err(ae1));

    dbus_access_ctrl #(.BYPASS_RESP(1'b0)) u_reg (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_accept(req_accept),
        .dreq_valid(v0), .dreq_addr(a0), .dreq_size(s0), .dreq_strobe(b0), .dreq_data(d0),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .rdata(r0), .stall(st0), .addr_err(ae0));

    assign o_valid  = sel ? v1  : v0;
    assign o_stall  = sel ? st1 : st0;
    assign o_err    = sel ? ae1 : ae0;
    assign o_addr   = sel ? a1  : a0;
    assign o_data   = sel ? d1  : d0;
    assign o_rdata  = sel ? r1  : r0;
    assign o_size   = sel ? s1  : s0;
    assign o_strobe = sel ? b1  : b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s (bypass=%0b) got=%h want=%h t=%0t", tag, sel, obs, exp, $time);
        end
    endtask

    // ---- reference model: byte-lane view of an access ----
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_strobe(input bit wr, input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] s;
        int off, nb;
        off = int'(a[1:0]);
        nb  = nbytes(sz);
        for (int i = 0; i < 4; i++) s[i] = wr && (i >= off) && (i < off + nb);
        return s;
    endfunction

    function automatic logic [31:0] m_data(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] d;
        int nb;
        nb = nbytes(sz);
        for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % nb) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] m_mask(input logic [1:0] sz);
        return (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_done(input bit wr, input logic [1:0] sz, input logic [31:0] exp_rd);
        @(negedge clk);
        chk("done_stall", {31'd0, o_stall}, 32'd0);
        chk("done_noreissue", {31'd0, o_valid}, 32'd0);
        if (!wr) chk("done_rdata", o_rdata & m_mask(sz), exp_rd);
        next_cycle();
    endtask

    // One memory-stage request: ad = ADDR wait cycles, dd = cycles from addr_ok to data_ok,
    // acc = DONE cycles with req_accept low before the stage moves on.
    task automatic run_txn(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] raw,
                           input int ad, input int dd, input int acc);
        logic [3:0]  e_strb;
        logic [31:0] e_data, e_rd;
        bit          mis;
        mis    = (a % nbytes(sz)) != 0;
        e_strb = m_strobe(wr, sz, a);
        e_data = m_data(sz, wd);
        e_rd   = (raw >> (8 * a[1:0])) & m_mask(sz);

        req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
        req_accept = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        @(negedge clk);
        chk("idle_err", {31'd0, o_err}, {31'd0, mis});
        chk("idle_stall", {31'd0, o_stall}, {31'd0, !mis});
        chk("idle_valid", {31'd0, o_valid}, 32'd0);
        next_cycle();
        if (mis) begin
            req_valid = 1'b0;
            @(negedge clk);
            chk("mis_noissue", {31'd0, o_valid}, 32'd0);
            chk("mis_err_clear", {31'd0, o_err}, 32'd0);
            next_cycle();
            return;
        end

        for (int i = 0; i <= ad; i++) begin
            if (i == ad) begin
                dresp_addr_ok = 1'b1;
                if (dd == 0) begin
                    dresp_data_ok = 1'b1; dresp_data = raw; req_accept = (acc == 0);
                end
            end else begin
                req_addr = $urandom; req_wdata = $urandom;
                req_size = 2'($urandom_range(0, 3)); req_write = 1'($urandom);
            end
            @(negedge clk);
            chk("addr_valid", {31'd0, o_valid}, 32'd1);
            chk("addr_err_low", {31'd0, o_err}, 32'd0);
            chk("addr_hold", o_addr, a);
            chk("size_hold", {30'd0, o_size}, {30'd0, sz});
            chk("strobe_hold", {28'd0, o_strobe}, {28'd0, e_strb});
            if (wr) chk("wdata_hold", o_data, e_data);
            if (dd == 0 && i == ad) begin
                chk("cmpl_stall", {31'd0, o_stall}, {31'd0, !sel});
                if (sel && !wr) chk("cmpl_rdata", o_rdata & m_mask(sz), e_rd);
            end else begin
                chk("addr_stall", {31'd0, o_stall}, 32'd1);
            end
            next_cycle();
        end
        dresp_addr_ok = 1'b0;

        if (dd > 0) begin
            for (int i = 1; i <= dd; i++) begin
                dresp_data_ok = (i == dd);
                dresp_data    = (i == dd) ? raw : $urandom;
                req_accept    = (i == dd) && (acc == 0);
                @(negedge clk);
                chk("data_valid", {31'd0, o_valid}, 32'd0);
                if (i == dd) begin
                    chk("cmpl_stall", {31'd0, o_stall}, {31'd0, !sel});
                    if (sel && !wr) chk("cmpl_rdata", o_rdata & m_mask(sz), e_rd);
                end else begin
                    chk("data_stall", {31'd0, o_stall}, 32'd1);
                end
                next_cycle();
            end
        end
        dresp_data_ok = 1'b0; dresp_data = $urandom; req_accept = 1'b0;

        if (!(sel && acc == 0)) begin
            for (int i = 0; i < acc; i++) check_done(wr, sz, e_rd);
            req_accept = 1'b1;
            check_done(wr, sz, e_rd);
            req_accept = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        chk({tag, "_valid"},  {31'd0, o_valid}, 32'd0);
        chk({tag, "_stall"},  {31'd0, o_stall}, 32'd0);
        chk({tag, "_err"},    {31'd0, o_err}, 32'd0);
        chk({tag, "_addr"},   o_addr, 32'd0);
        chk({tag, "_size"},   {30'd0, o_size}, 32'd0);
        chk({tag, "_strobe"}, {28'd0, o_strobe}, 32'd0);
        chk({tag, "_data"},   o_data, 32'd0);
        chk({tag, "_rdata"},  o_rdata, 32'd0);
        next_cycle();
    endtask

    task automatic run_phase(input bit byp);
        logic [31:0] a, wd, raw;
        logic [1:0]  sz;
        sel = byp;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_accept = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'd0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        check_all_zero("reset");

        run_txn(1'b0, 2'd2, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 2, 0);
        run_txn(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1, 1, 0);
        run_txn(1'b0, 2'd1, 32'h0000_2002, 32'h0, 32'h1234_5678, 0, 1, 1);
        run_txn(1'b0, 2'd1, 32'h0000_2001, 32'h0, 32'h0, 0, 0, 0);
        run_txn(1'b1, 2'd1, 32'h0000_3002, 32'h0000_BEEF, 32'h0, 5, 0, 0);
        run_txn(1'b0, 2'd0, 32'h0000_4001, 32'h0, 32'hCAFE_F00D, 2, 3, 3);

        for (int n = 0; n < 40; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
            wd  = $urandom;
            raw = $urandom;
            run_txn(1'($urandom), sz, a, wd, raw,
                    $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // reset while waiting for data_ok
        run_txn(1'b0, 2'd2, 32'h0000_5004, 32'h0, 32'h8765_4321, 0, 1, 0);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h0000_6008;
        req_wdata = 32'h1111_2222;
        next_cycle();
        dresp_addr_ok = 1'b1;
        next_cycle();
        dresp_addr_ok = 1'b0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0; req_valid = 1'b0;
        check_all_zero("midreset");
        run_txn(1'b0, 2'd0, 32'h0000_7002, 32'h0, 32'h00AB_0000, 1, 2, 1);
        req_valid = 1'b0;
    endtask

    initial begin
        sel = 1'b1;
        #1;
        run_phase(1'b1);
        run_phase(1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
